hpm_event_collector: RTL and testbench

//  Upstream stage of the HPM counter bank. Pipeline units report per-cycle event multiplicities
//  (e.g. 2 instrs retired in one cycle). The counter bank adds at most 1 per event per cycle.

---
 rtl/hpm_event_collector.sv | 74 +++++++
 tb/tb_hpm_event_collector.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hpm_event_collector.sv
`default_nettype none
// ============================================================================
// Module   : hpm_event_collector
// Purpose  : Front end of the HPM counter bank. Registers the per-cycle event
//            multiplicities reported by the pipeline and holds them in one
//            backlog accumulator per event. Each backlog drains at one count
//            per cycle onto events_o. A sticky lost flag marks any backlog
//            that saturated and dropped counts.
//            ACC_W must be at least CNT_W+1.
// Revision : 1.0 - initial release
// ============================================================================
module hpm_event_collector #(
  parameter int HPM_NUM_EVENTS = 28,
  parameter int CNT_W          = 2,
  parameter int ACC_W          = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            enable_i,
  input  logic [HPM_NUM_EVENTS*CNT_W-1:0] raw_cnt_i,
  input  logic                            clr_ovf_i,
  output logic [HPM_NUM_EVENTS:1]         events_o,
  output logic [HPM_NUM_EVENTS:1]         lost_o,
  output logic                            idle_o
);

  // Sums are formed one bit wider than the accumulator so saturation is visible.
  localparam logic [ACC_W:0] c_ACC_MAX = {1'b0, {ACC_W{1'b1}}};
  localparam int             c_PAD_W   = ACC_W + 1 - CNT_W;

  // Per event: something still in flight (registered input or backlog).
  logic [HPM_NUM_EVENTS:1] w_busy;

  for (genvar gi = 1; gi <= HPM_NUM_EVENTS; gi++) begin : g_evt
    logic [CNT_W-1:0] r_in;
    logic [ACC_W-1:0] r_acc;
    logic             r_nz;    // registered (r_acc != 0); doubles as the drain strobe
    logic             r_lost;
    logic [ACC_W:0]   w_sum;
    logic [ACC_W-1:0] w_acc_d;
    logic             w_sat;

    // New backlog: add the registered count, remove the unit drained this cycle.
    // r_nz implies r_acc >= 1, so the subtraction cannot underflow.
    assign w_sum   = {{c_PAD_W{1'b0}}, r_in} + {1'b0, r_acc} - {{ACC_W{1'b0}}, r_nz};
    assign w_sat   = (w_sum > c_ACC_MAX);
    assign w_acc_d = w_sat ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];

    // Input register, backlog accumulator, drain flag and sticky lost flag.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_in   <= '0;
        r_acc  <= '0;
        r_nz   <= 1'b0;
        r_lost <= 1'b0;
      end else begin
        r_in   <= enable_i ? raw_cnt_i[(gi-1)*CNT_W +: CNT_W] : '0;
        r_acc  <= w_acc_d;
        r_nz   <= (w_acc_d != '0);
        // A saturation in the clearing cycle keeps the flag set.
        r_lost <= w_sat | (r_lost & ~clr_ovf_i);
      end
    end

    assign events_o[gi] = r_nz;
    assign lost_o[gi]   = r_lost;
    assign w_busy[gi]   = (r_in != '0) | r_nz;
  end

  // Idle once nothing is registered and every backlog is empty.
  assign idle_o = ~|w_busy;

endmodule
`default_nettype wire

// File: tb/tb_hpm_event_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_hpm_event_collector
// Purpose  : Directed scoreboard bench for hpm_event_collector. Stimulus
//            pushes hand-computed pulse and status expectations tagged with
//            the cycle they are due; a monitor pops and compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hpm_event_collector;

  localparam int N  = 28;
  localparam int CW = 2;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          clr;
  logic [N*CW-1:0] raw;
  logic [N:1]    events;
  logic [N:1]    lost;
  logic          idle;

  hpm_event_collector #(
    .HPM_NUM_EVENTS(N),
    .CNT_W         (CW),
    .ACC_W         (AW)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .enable_i (enable),
    .raw_cnt_i(raw),
    .clr_ovf_i(clr),
    .events_o (events),
    .lost_o   (lost),
    .idle_o   (idle)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic [N:1] v;
  } pulse_t;

  typedef struct {
    int         c;
    logic [N:1] lost;
    logic       idle;
  } stat_t;

  pulse_t pq[$];
  stat_t  sq[$];
  int     n_cmp = 0;
  int     n_err = 0;

  function automatic logic [N:1] bitv(input int i);
    logic [N:1] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic exp_pulses(input int c_from, input int c_to, input logic [N:1] v);
    pulse_t p;
    for (int c = c_from; c <= c_to; c++) begin
      p.c = c;
      p.v = v;
      pq.push_back(p);
    end
  endtask

  task automatic exp_stat(input int c, input logic [N:1] l, input logic i);
    stat_t s;
    s.c    = c;
    s.lost = l;
    s.idle = i;
    sq.push_back(s);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic set_raw(input int ev, input int v);
    raw[(ev-1)*CW +: CW] = v[CW-1:0];
  endtask

  // Monitor: compares whatever is due this cycle, flags unexpected pulses.
  always @(negedge clk) begin
    pulse_t p;
    stat_t  s;
    if (pq.size() > 0 && pq[0].c == cyc) begin
      p = pq.pop_front();
      n_cmp++;
      if (events !== p.v) begin
        n_err++;
        $display("FAIL events cyc=%0d got=%h want=%h", cyc, events, p.v);
      end
    end else if (events !== '0) begin
      n_cmp++;
      n_err++;
      $display("FAIL unexpected_pulse cyc=%0d got=%h want=0", cyc, events);
    end
    while (sq.size() > 0 && sq[0].c == cyc) begin
      s = sq.pop_front();
      n_cmp++;
      if (lost !== s.lost || idle !== s.idle) begin
        n_err++;
        $display("FAIL status cyc=%0d got lost=%h idle=%b want lost=%h idle=%b",
                 cyc, lost, idle, s.lost, s.idle);
      end
    end
  end

  initial begin
    int t0;
    rst    = 1'b1;
    enable = 1'b1;
    clr    = 1'b0;
    raw    = '0;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Reset state
    exp_stat(cyc, '0, 1'b1);
    step();
    step();

    // T1: single count on event 5
    t0 = cyc;
    set_raw(5, 1);
    exp_pulses(t0 + 2, t0 + 2, bitv(5));
    exp_stat(t0 + 1, '0, 1'b0);
    exp_stat(t0 + 2, '0, 1'b0);
    exp_stat(t0 + 3, '0, 1'b1);
    step();
    raw = '0;
    wait_until(t0 + 6);

    // T2: 3 then 2 on event 1 -> five consecutive pulses
    t0 = cyc;
    exp_pulses(t0 + 2, t0 + 6, bitv(1));
    exp_stat(t0 + 6, '0, 1'b0);
    exp_stat(t0 + 7, '0, 1'b1);
    set_raw(1, 3);
    step();
    set_raw(1, 2);
    step();
    raw = '0;
    wait_until(t0 + 10);

    // T3: event 3 at max rate for 10 cycles -> saturation
    t0 = cyc;
    exp_pulses(t0 + 2, t0 + 25, bitv(3));
    exp_stat(t0 + 8,  '0,      1'b0);
    exp_stat(t0 + 9,  bitv(3), 1'b0);
    exp_stat(t0 + 25, bitv(3), 1'b0);
    exp_stat(t0 + 26, bitv(3), 1'b1);
    set_raw(3, 3);
    wait_until(t0 + 10);
    raw = '0;
    wait_until(t0 + 30);

    // T4: clear coincides with event 4 saturating; then clear alone
    t0 = cyc;
    exp_pulses(t0 + 2, t0 + 23, bitv(4));
    exp_stat(t0 + 8,  bitv(3), 1'b0);
    exp_stat(t0 + 9,  bitv(4), 1'b0);
    exp_stat(t0 + 10, '0,      1'b0);
    exp_stat(t0 + 24, '0,      1'b1);
    set_raw(4, 3);
    wait_until(t0 + 8);
    raw = '0;
    clr = 1'b1;
    step();
    step();
    clr = 1'b0;
    wait_until(t0 + 28);

    // T5a: backlog of 6 on event 2, then disable with raw still present
    t0 = cyc;
    exp_pulses(t0 + 2, t0 + 9, bitv(2));
    exp_stat(t0 + 9,  '0, 1'b0);
    exp_stat(t0 + 10, '0, 1'b1);
    set_raw(2, 3);
    step();
    step();
    set_raw(2, 2);
    step();
    enable = 1'b0;
    set_raw(2, 3);
    wait_until(t0 + 13);
    enable = 1'b1;
    raw    = '0;
    wait_until(t0 + 16);

    // T5b: same build-up, reset after two pulses
    t0 = cyc;
    exp_pulses(t0 + 2, t0 + 3, bitv(2));
    exp_stat(t0 + 3, '0, 1'b0);
    exp_stat(t0 + 4, '0, 1'b1);
    exp_stat(t0 + 5, '0, 1'b1);
    set_raw(2, 3);
    step();
    step();
    set_raw(2, 2);
    step();
    raw = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    wait_until(t0 + 10);

    // T6: every event counts once in the same cycle
    t0 = cyc;
    exp_pulses(t0 + 2, t0 + 2, '1);
    exp_stat(t0 + 2, '0, 1'b0);
    exp_stat(t0 + 3, '0, 1'b1);
    for (int e = 1; e <= N; e++) set_raw(e, 1);
    step();
    raw = '0;
    wait_until(t0 + 8);

    if (pq.size() != 0) begin
      n_err += pq.size();
      $display("FAIL pulses_left got=%0d want=0", pq.size());
    end
    if (sq.size() != 0) begin
      n_err += sq.size();
      $display("FAIL status_left got=%0d want=0", sq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
